// File: rtl/ram_pkt_controller.sv
// ram_pkt_controller
//   Sequences one packet transfer through the RAM system: pulses the data
//   generator, writes PKT_LEN generator words into one RAM bank, then streams
//   that bank to a downstream consumer over valid/ready. The bank (address
//   MSB) alternates per packet so consecutive packets ping-pong.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_req                   transfer request pulse (honoured only when idle)
//   o_busy                  controller not idle
//   o_done                  1-clk pulse after the last word is accepted
//   o_bank                  bank of the packet being processed
//   o_gen_start             1-clk start pulse to the data generator
//   i_gen_valid/i_gen_data  generator beat
//   o_ram_we/waddr/wdata    RAM write port (registered generator beat)
//   o_ram_re/raddr          RAM read request
//   i_ram_rdata             RAM read data, valid one clk after o_ram_re
//   o_rd_valid/o_rd_data    output stream, held until accepted
//   i_rd_ready              downstream ready
//   o_err, o_err_cnt        stream checker result (only with CHECK_EN)
//
// Build option
//   CHECK_EN  adds a comparator that expects word k of each packet to equal
//             the packet's first written word + k; mismatches set sticky
//             o_err and bump the saturating o_err_cnt.

module ram_pkt_controller #(
    parameter int PKT_LEN = 64,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_bank,
    output logic              o_gen_start,
    input  logic              i_gen_valid,
    input  logic [DATA_W-1:0] i_gen_data,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_waddr,
    output logic [DATA_W-1:0] o_ram_wdata,
    output logic              o_ram_re,
    output logic [ADDR_W-1:0] o_ram_raddr,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_rd_ready
`ifdef CHECK_EN
    ,
    output logic              o_err,
    output logic [15:0]       o_err_cnt
`endif
);

    localparam int CNT_W = $clog2(PKT_LEN);
    localparam logic [CNT_W:0] LAST_IDX = (CNT_W + 1)'(PKT_LEN - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_KICK  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state;
    logic              bank;
    logic [CNT_W-1:0]  wr_cnt;
    logic              wr_last;   // last beat registered; its RAM write issues next clk
    logic [CNT_W:0]    rd_cnt;    // reads issued this packet (MSB = all issued)
    logic [CNT_W:0]    acc_cnt;   // words accepted downstream this packet
    logic              inflight;  // read issued last clk, data arrives now
    logic [DATA_W-1:0] fifo_mem [2];
    logic              fifo_wp;
    logic              fifo_rp;
    logic [1:0]        fifo_cnt;

    logic pop;
    logic gen_beat;
    logic rd_issue;

    always_comb begin
        pop      = (fifo_cnt != 2'd0) && i_rd_ready;
        gen_beat = (state == S_WRITE) && !wr_last && i_gen_valid;
        // Issue only if the word can be guaranteed a FIFO slot when it lands.
        rd_issue = (state == S_READ) && !rd_cnt[CNT_W] &&
                   (({1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop}) < 3'd2);
    end

    always_comb begin
        o_busy      = (state != S_IDLE);
        o_gen_start = (state == S_KICK);
        o_done      = (state == S_DONE);
        o_bank      = bank;
        o_ram_re    = rd_issue;
        o_ram_raddr = {bank, rd_cnt[CNT_W-1:0]};
        o_rd_valid  = (fifo_cnt != 2'd0);
        o_rd_data   = fifo_mem[fifo_rp];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            bank        <= 1'b0;
            wr_cnt      <= '0;
            wr_last     <= 1'b0;
            rd_cnt      <= '0;
            acc_cnt     <= '0;
            inflight    <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            fifo_wp     <= 1'b0;
            fifo_rp     <= 1'b0;
            fifo_cnt    <= 2'd0;
            o_ram_we    <= 1'b0;
            o_ram_waddr <= '0;
            o_ram_wdata <= '0;
        end else begin
            case (state)
                S_IDLE:  if (i_req) state <= S_KICK;
                S_KICK:  state <= S_WRITE;
                S_WRITE: if (wr_last) begin
                    wr_last <= 1'b0;
                    state   <= S_READ;
                end
                S_READ:  if (pop && (acc_cnt == LAST_IDX)) state <= S_DONE;
                S_DONE: begin
                    bank    <= ~bank;
                    rd_cnt  <= '0;
                    acc_cnt <= '0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // Write path: one-clk registered copy of the generator beat.
            o_ram_we <= gen_beat;
            if (gen_beat) begin
                o_ram_wdata <= i_gen_data;
                o_ram_waddr <= {bank, wr_cnt};
                wr_cnt      <= wr_cnt + 1'b1;
                if (wr_cnt == '1) wr_last <= 1'b1;
            end

            // Read path: issue, capture into the 2-entry FIFO, drain on accept.
            inflight <= rd_issue;
            if (rd_issue) rd_cnt <= rd_cnt + 1'b1;
            if (inflight) begin
                fifo_mem[fifo_wp] <= i_ram_rdata;
                fifo_wp           <= ~fifo_wp;
            end
            if (pop && (state == S_READ)) begin
                fifo_rp <= ~fifo_rp;
                acc_cnt <= acc_cnt + 1'b1;
            end
            fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
        end
    end

`ifdef CHECK_EN
    logic [DATA_W-1:0] exp_base;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            exp_base  <= '0;
            o_err     <= 1'b0;
            o_err_cnt <= '0;
        end else begin
            if (gen_beat && (wr_cnt == '0)) exp_base <= i_gen_data;
            if (pop && (o_rd_data != (exp_base + DATA_W'(acc_cnt)))) begin
                o_err <= 1'b1;
                if (o_err_cnt != '1) o_err_cnt <= o_err_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ram_pkt_controller.sv
module tb_ram_pkt_controller;

    localparam int PKT_LEN = 64;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 32;

    logic              i_clk;
    logic              i_rst_n;
    logic              i_req;
    logic              o_busy;
    logic              o_done;
    logic              o_bank;
    logic              o_gen_start;
    logic              i_gen_valid;
    logic [DATA_W-1:0] i_gen_data;
    logic              o_ram_we;
    logic [ADDR_W-1:0] o_ram_waddr;
    logic [DATA_W-1:0] o_ram_wdata;
    logic              o_ram_re;
    logic [ADDR_W-1:0] o_ram_raddr;
    logic [DATA_W-1:0] i_ram_rdata;
    logic              o_rd_valid;
    logic [DATA_W-1:0] o_rd_data;
    logic              i_rd_ready;
`ifdef CHECK_EN
    logic              o_err;
    logic [15:0]       o_err_cnt;
`endif

    ram_pkt_controller #(
        .PKT_LEN(PKT_LEN),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_req      (i_req),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_bank     (o_bank),
        .o_gen_start(o_gen_start),
        .i_gen_valid(i_gen_valid),
        .i_gen_data (i_gen_data),
        .o_ram_we   (o_ram_we),
        .o_ram_waddr(o_ram_waddr),
        .o_ram_wdata(o_ram_wdata),
        .o_ram_re   (o_ram_re),
        .o_ram_raddr(o_ram_raddr),
        .i_ram_rdata(i_ram_rdata),
        .o_rd_valid (o_rd_valid),
        .o_rd_data  (o_rd_data),
        .i_rd_ready (i_rd_ready)
`ifdef CHECK_EN
        ,
        .o_err      (o_err),
        .o_err_cnt  (o_err_cnt)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Behavioural RAM: synchronous write, one-clk read latency; can corrupt one word.
    logic [DATA_W-1:0] ram [2*PKT_LEN];
    bit corrupt_en = 1'b0;
    localparam int CORRUPT_OFF = 10;

    always @(posedge i_clk) begin
        if (o_ram_we) ram[int'(o_ram_waddr)] <= o_ram_wdata;
        if (o_ram_re) begin
            if (corrupt_en && (int'(o_ram_raddr) % PKT_LEN) == CORRUPT_OFF)
                i_ram_rdata <= ram[int'(o_ram_raddr)] ^ 32'h1;
            else
                i_ram_rdata <= ram[int'(o_ram_raddr)];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    bit                exp_bank = 1'b0;
    logic [DATA_W-1:0] gen_base;
    bit                gen_on;
    int                gen_sent;
    int                wr_idx, rd_idx, starts, dones;
    int                ready_mode;
    bit                noise;
    bit                prev_stall;
    logic [DATA_W-1:0] prev_data;
    int                cyc, first_acc, last_acc;

    function automatic logic [DATA_W-1:0] exp_word(input int k);
        logic [DATA_W-1:0] w;
        w = gen_base + DATA_W'(k);
        if (corrupt_en && k == CORRUPT_OFF) w = w ^ 32'h1;
        return w;
    endfunction

    // One clock: observe at the negedge, then drive just after the posedge.
    task automatic tick();
        @(negedge i_clk);
        if (o_gen_start) begin
            starts++;
            gen_on = 1'b1;
        end
        if (o_ram_we) begin
            check_val("waddr", 64'(o_ram_waddr),
                      64'(int'(exp_bank) * PKT_LEN + (wr_idx % PKT_LEN)));
            check_val("wdata", 64'(o_ram_wdata), 64'(gen_base + DATA_W'(wr_idx)));
            wr_idx++;
        end
        if (prev_stall) begin
            check_val("valid_held", 64'(o_rd_valid), 64'(1));
            check_val("data_stable", 64'(o_rd_data), 64'(prev_data));
        end
        if (o_rd_valid && i_rd_ready) begin
            check_val("rdata", 64'(o_rd_data), 64'(exp_word(rd_idx)));
            if (rd_idx == 0) first_acc = cyc;
            last_acc = cyc;
            rd_idx++;
        end
        prev_stall = o_rd_valid && !i_rd_ready;
        prev_data  = o_rd_data;
        if (o_done) dones++;

        @(posedge i_clk);
        #1;
        i_req = noise && o_busy && !o_done && ($urandom_range(5) == 0);
        if (gen_on && gen_sent < PKT_LEN && $urandom_range(3) != 0) begin
            i_gen_valid = 1'b1;
            i_gen_data  = gen_base + DATA_W'(gen_sent);
            gen_sent++;
        end else begin
            // Stray beats only where the controller must ignore them.
            i_gen_valid = noise && (!gen_on || rd_idx > 0) && ($urandom_range(1) == 1);
            i_gen_data  = $urandom;
        end
        case (ready_mode)
            0:       i_rd_ready = 1'b1;
            1:       i_rd_ready = ~i_rd_ready;
            default: i_rd_ready = ($urandom_range(2) != 0);
        endcase
        cyc++;
    endtask

    // Runs one packet; if rst_at >= 0, returns (without completing) once that
    // many words have been accepted.
    task automatic run_packet(input logic [DATA_W-1:0] base, input int mode,
                              input bit nz, input int rst_at);
        int budget;
        gen_base   = base;
        gen_on     = 1'b0;
        gen_sent   = 0;
        wr_idx     = 0;
        rd_idx     = 0;
        starts     = 0;
        dones      = 0;
        prev_stall = 1'b0;
        ready_mode = mode;
        noise      = nz;
        first_acc  = 0;
        last_acc   = 0;
        @(posedge i_clk);
        #1;
        i_req = 1'b1;
        budget = 0;
        while (dones == 0 && budget < 3000) begin
            tick();
            budget++;
            if (rst_at >= 0 && rd_idx == rst_at) return;
        end
        check_val("done_seen", 64'(dones), 64'(1));
        exp_bank = ~exp_bank;
        noise = 1'b0;
        repeat (4) tick();
        check_val("one_gen_start", 64'(starts), 64'(1));
        check_val("one_done", 64'(dones), 64'(1));
        check_val("writes", 64'(wr_idx), 64'(PKT_LEN));
        check_val("accepts", 64'(rd_idx), 64'(PKT_LEN));
        check_val("bank_after", 64'(o_bank), 64'(exp_bank));
        check_val("idle_after", 64'(o_busy), 64'(0));
        if (mode == 0)
            check_val("back_to_back", 64'(last_acc - first_acc), 64'(PKT_LEN - 1));
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_ctl"}, 64'({o_busy, o_done, o_bank, o_gen_start,
                                      o_ram_we, o_ram_re, o_rd_valid}), 64'(0));
        check_val({tag, "_addr"}, 64'({o_ram_waddr, o_ram_raddr}), 64'(0));
        check_val({tag, "_wdata"}, 64'(o_ram_wdata), 64'(0));
        check_val({tag, "_rdata"}, 64'(o_rd_data), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n     = 1'b0;
        i_req       = 1'b0;
        i_gen_valid = 1'b0;
        i_gen_data  = '0;
        i_rd_ready  = 1'b1;
        cyc         = 0;
        noise       = 1'b0;
        ready_mode  = 0;
        gen_on      = 1'b0;
        gen_sent    = 0;
        rd_idx      = 0;
        wr_idx      = 0;
        prev_stall  = 1'b0;
        #1;
        check_outputs_zero("reset");
        repeat (3) @(posedge i_clk);
        #3;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check_outputs_zero("post_reset");
`ifdef CHECK_EN
        check_val("err_reset", 64'({o_err, o_err_cnt}), 64'(0));
`endif

        // Directed packets: 0..63 into bank 0, 64..127 into bank 1.
        run_packet(32'd0, 0, 1'b0, -1);
        run_packet(32'd64, 0, 1'b0, -1);

        // Backpressure: alternating ready, then random ready.
        run_packet($urandom, 1, 1'b0, -1);
        run_packet($urandom, 2, 1'b0, -1);

        // Spurious requests and generator beats while busy.
        run_packet($urandom, 2, 1'b1, -1);
        run_packet($urandom, 0, 1'b1, -1);
`ifdef CHECK_EN
        check_val("no_false_err", 64'({o_err, o_err_cnt}), 64'(0));
`endif

        // Asynchronous reset in the middle of the read phase.
        run_packet($urandom, 0, 1'b0, 30);
        i_rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        i_req       = 1'b0;
        i_gen_valid = 1'b0;
        noise       = 1'b0;
        exp_bank    = 1'b0;
        repeat (2) @(posedge i_clk);
        #3;
        i_rst_n = 1'b1;
        run_packet($urandom, 2, 1'b0, -1);

`ifdef CHECK_EN
        corrupt_en = 1'b1;
        run_packet($urandom, 0, 1'b0, -1);
        corrupt_en = 1'b0;
        check_val("err_flag", 64'(o_err), 64'(1));
        check_val("err_cnt", 64'(o_err_cnt), 64'(1));
        repeat (5) tick();
        check_val("err_held", 64'({o_err, o_err_cnt}), 64'({1'b1, 16'd1}));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
